cdb_arbiter: RTL and testbench

Round-robin arbiter that shares the single common data bus (CDB) among N functional-unit result ports. Each port buffers up to two completed results (tag + data) in a private 2-entry FIFO. Each cycle the arbiter grants one non-empty port and broadcasts its head entry on the registered CDB outputs. Those outputs feed the `cdb_valid` / `cdb_tag` / `cdb_data` inputs of every reservation station and the register-status logic.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_req_fifo.sv | 81 ++++++++
 rtl/cdb_arbiter.sv | 154 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared common-data-bus definitions. The arbiter, reservation
//               stations and register-status logic all import this package
//               so tag/data widths and the null tag agree everywhere.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int CDB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;

    // All-ones tag marks "no producer"; it is never placed on the bus.
    localparam logic [CDB_TAG_W-1:0] CDB_NONE = {CDB_TAG_W{1'b1}};

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry;

endpackage
`default_nettype wire

// File: rtl/cdb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_req_fifo
// Description : 2-entry FIFO buffering completed results for one CDB port.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               push_i, din_i   - write strobe and entry
//               pop_i           - remove head entry
//               head_o          - current head entry
//               count_o         - occupancy (0..2)
//               full_o          - occupancy == 2
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_req_fifo #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   count_q, count_d;
    logic         w_do_push;
    logic         w_do_pop;

    // Guards keep the FIFO self-consistent even if a caller misbehaves.
    assign w_do_push = push_i & (count_q != 2'd2);
    assign w_do_pop  = pop_i  & (count_q != 2'd0);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (w_do_push) begin
            wr_d = ~wr_q;
        end
        if (w_do_pop) begin
            rd_d = ~rd_q;
        end
        // Push+pop together leaves occupancy unchanged; with one entry the
        // read pointer moves onto the slot being written, so the new entry
        // becomes head.
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = (count_q == 2'd2);

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbiter sharing the common data bus among N_REQ
//               result ports, each buffered by a 2-entry FIFO. One head entry
//               is broadcast per cycle on registered outputs.
// Ports       : clk, rst                  - clock, async active-high reset
//               req_valid/req_tag/req_data - per-port result (packed by port)
//               req_ready                  - per-port FIFO can accept
//               cdb_valid/cdb_tag/cdb_data - registered broadcast
//               grant                      - one-hot source of broadcast
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int               N_REQ  = 4,
    parameter int               TAG_W  = CDB_TAG_W,
    parameter int               DATA_W = CDB_DATA_W,
    parameter logic [TAG_W-1:0] NONE   = {TAG_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [N_REQ-1:0]        grant
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int ENT_W = TAG_W + DATA_W;

    logic [N_REQ-1:0]  w_full;
    logic [N_REQ-1:0]  w_nonempty;
    logic [N_REQ-1:0]  w_push;
    logic [N_REQ-1:0]  w_pop;
    logic [ENT_W-1:0]  w_head [N_REQ];
    logic [PTR_W:0]    w_pick;
    logic              w_found;
    logic [PTR_W-1:0]  w_winner;
    logic [ENT_W-1:0]  w_sel;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [N_REQ-1:0]  grant_q, grant_d;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    // Scanning offsets high-to-low lets the smallest offset win last.
    function automatic logic [PTR_W:0] f_rr_pick(
        input logic [N_REQ-1:0] nonempty,
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W:0] pick;
        int             idx;
        pick = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (nonempty[idx]) begin
                pick = {1'b1, idx[PTR_W-1:0]};
            end
        end
        return pick;
    endfunction

    // Ready reflects start-of-cycle occupancy only: a full FIFO being popped
    // this cycle still refuses a push.
    assign req_ready = ~{N_REQ{rst}} & ~w_full;

    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_port
            logic [1:0] w_count;

            // Null-tag results complete the handshake but are discarded.
            assign w_push[k] = req_valid[k] & req_ready[k]
                             & (req_tag[k*TAG_W +: TAG_W] != NONE);
            assign w_pop[k]  = w_found & (w_winner == PTR_W'(k));

            cdb_req_fifo #(
                .W (ENT_W)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push_i  (w_push[k]),
                .din_i   ({req_tag[k*TAG_W +: TAG_W], req_data[k*DATA_W +: DATA_W]}),
                .pop_i   (w_pop[k]),
                .head_o  (w_head[k]),
                .count_o (w_count),
                .full_o  (w_full[k])
            );

            assign w_nonempty[k] = (w_count != 2'd0);
        end
    endgenerate

    assign w_pick   = f_rr_pick(w_nonempty, ptr_q);
    assign w_found  = w_pick[PTR_W];
    assign w_winner = w_pick[PTR_W-1:0];
    assign w_sel    = w_head[w_winner];

    always_comb begin
        ptr_d       = ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = NONE;
        cdb_data_d  = cdb_data_q;
        grant_d     = '0;
        if (w_found) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = w_sel[ENT_W-1 -: TAG_W];
            cdb_data_d  = w_sel[DATA_W-1:0];
            for (int k = 0; k < N_REQ; k++) begin
                if (w_winner == PTR_W'(k)) begin
                    grant_d[k] = 1'b1;
                end
            end
            if (int'(w_winner) == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = w_winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= NONE;
            cdb_data_q  <= '0;
            grant_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            grant_q     <= grant_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign grant     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter: directed scenarios then
//               random traffic, compared against a queue-based model of the
//               per-port buffers and round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int         N  = 4;
    localparam int         TW = 5;
    localparam int         DW = 32;
    localparam logic [4:0] NULL_TAG = 5'h1F;

    typedef struct {
        logic [TW-1:0] t;
        logic [DW-1:0] d;
    } ent_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [N-1:0]    grant;

    int n_checks;
    int n_errors;

    // Reference model state
    ent_t          mq[N][$];
    int            m_ptr;
    logic [DW-1:0] m_last;

    cdb_arbiter #(
        .N_REQ  (N),
        .TAG_W  (TW),
        .DATA_W (DW),
        .NONE   (NULL_TAG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_port(input int k, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_valid[k]         = v;
        req_tag[k*TW +: TW]  = t;
        req_data[k*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) mq[k].delete();
        m_ptr  = 0;
        m_last = '0;
    endtask

    // One clock: check ready, advance the model, take the edge, check outputs.
    task automatic step();
        logic [N-1:0]  e_ready;
        logic          e_valid;
        logic [TW-1:0] e_tag;
        logic [N-1:0]  e_grant;
        int            win;
        ent_t          e;
        for (int k = 0; k < N; k++) e_ready[k] = (mq[k].size() < 2);
        chk("req_ready", 64'(req_ready), 64'(e_ready));

        win = -1;
        for (int off = 0; off < N; off++) begin
            if (win < 0 && mq[(m_ptr + off) % N].size() > 0) win = (m_ptr + off) % N;
        end
        if (win >= 0) begin
            e       = mq[win].pop_front();
            e_valid = 1'b1;
            e_tag   = e.t;
            m_last  = e.d;
            e_grant = N'(1 << win);
            m_ptr   = (win + 1) % N;
        end else begin
            e_valid = 1'b0;
            e_tag   = NULL_TAG;
            e_grant = '0;
        end
        for (int k = 0; k < N; k++) begin
            if (req_valid[k] && e_ready[k] && req_tag[k*TW +: TW] != NULL_TAG) begin
                e.t = req_tag[k*TW +: TW];
                e.d = req_data[k*DW +: DW];
                mq[k].push_back(e);
            end
        end

        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        chk("cdb_tag",   64'(cdb_tag),   64'(e_tag));
        chk("grant",     64'(grant),     64'(e_grant));
        chk("cdb_data",  64'(cdb_data),  64'(m_last));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, 64'(cdb_valid), 64'd0);
        chk({name, "_tag"},   64'(cdb_tag),   64'(NULL_TAG));
        chk({name, "_data"},  64'(cdb_data),  64'd0);
        chk({name, "_grant"}, 64'(grant),     64'd0);
        chk({name, "_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_release", 64'(req_ready), 64'hF);

        // Reset mid-stream with three results buffered.
        set_port(0, 1'b1, 5'd1, 32'h1111_0000);
        set_port(1, 1'b1, 5'd2, 32'h2222_0000);
        set_port(2, 1'b1, 5'd4, 32'h4444_0000);
        step();
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_rst_hold");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_mid_rst", 64'(req_ready), 64'hF);
        step();
        chk("no_stale_broadcast", 64'(cdb_valid), 64'd0);

        // All four ports at once from ptr=0: grants in order 0,1,2,3.
        for (int k = 0; k < N; k++) set_port(k, 1'b1, TW'(8 + k), 32'hC0DE_0000 + DW'(k));
        step();
        clear_inputs();
        for (int k = 0; k < N; k++) begin
            step();
            chk("sim_order_grant", 64'(grant), 64'(1 << k));
            chk("sim_order_tag",   64'(cdb_tag), 64'(8 + k));
        end
        step();

        // Single result on port 2 (ptr back at 0).
        set_port(2, 1'b1, 5'd3, 32'hA5A5_A5A5);
        step();
        clear_inputs();
        step();
        chk("single_grant", 64'(grant),    64'h4);
        chk("single_data",  64'(cdb_data), 64'hA5A5_A5A5);
        chk("single_tag",   64'(cdb_tag),  64'd3);
        step();
        chk("single_one_cycle", 64'(cdb_valid), 64'd0);

        // Backpressure: port 1 three back-to-back, port 0 continuously fed.
        for (int c = 0; c < 6; c++) begin
            set_port(0, 1'b1, TW'(16 + c), 32'h0000_0100 + DW'(c));
            if (c < 3) set_port(1, 1'b1, TW'(20 + c), 32'h0001_0000 + DW'(c));
            else       set_port(1, 1'b0, '0, '0);
            step();
        end
        clear_inputs();
        repeat (6) step();

        // Null tag: handshake completes, nothing broadcast.
        set_port(0, 1'b1, NULL_TAG, 32'hDEAD_BEEF);
        step();
        clear_inputs();
        repeat (2) begin
            step();
            chk("null_no_valid", 64'(cdb_valid), 64'd0);
        end

        // Push and pop on port 3 in the same cycle.
        set_port(3, 1'b1, 5'd6, 32'h3333_0001);
        step();
        set_port(3, 1'b1, 5'd7, 32'h3333_0002);
        step();
        chk("pp_first_data", 64'(cdb_data), 64'h3333_0001);
        clear_inputs();
        step();
        chk("pp_second_data", 64'(cdb_data), 64'h3333_0002);
        chk("pp_second_tag",  64'(cdb_tag),  64'd7);
        step();

        // Random traffic; tags include the null tag occasionally.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                set_port(k, ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                         TW'($urandom_range(0, 31)), DW'($urandom));
            end
            step();
        end
        clear_inputs();
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
